// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the FIFO glue blocks.
//   MODE_TRUE / MODE_FALSE : string values accepted by the mode parameters
//   clogb2()               : index width for a given entry count (minimum 1)
// No ports.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam string MODE_TRUE  = "TRUE";
   localparam string MODE_FALSE = "FALSE";

   // Bits needed to index 'value' entries; a single entry still gets 1 bit.
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned v;
      int unsigned w;
      v = (value > 1) ? value - 1 : 1;
      w = 0;
      while (v > 0) begin
         w++;
         v = v >> 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/fifo_splitter_buf.sv
// -----------------------------------------------------------------------------
// fifo_splitter_buf
// Two-entry skid buffer between the input FIFO read side and the output ports.
// Push and pop may happen in the same cycle, also when full (the pop frees the
// slot the push lands in).
//   clk         : clock
//   nrst        : synchronous active-low reset (clears count and head pointer)
//   i_push      : write i_push_data into the tail slot
//   i_push_data : word to store
//   i_pop       : drop the head word
//   o_count     : number of stored words, 0..2
//   o_head      : head word (meaningful while o_count > 0)
// -----------------------------------------------------------------------------
module fifo_splitter_buf #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [1:0]        o_count,
   output logic [DATA_W-1:0] o_head
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_head;
   logic [1:0]        r_count;
   logic              w_wr_idx;

   // Tail slot is head + count mod 2. At count=2 this is the head slot, which
   // is exactly the one released by a simultaneous pop.
   assign w_wr_idx = r_head ^ r_count[0];

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[w_wr_idx] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_head  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_pop) begin
            r_head <= ~r_head;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_head];

endmodule

// File: rtl/fifo_splitter.sv
// -----------------------------------------------------------------------------
// fifo_splitter
// Reads words from one input FIFO and writes them, one word per cycle, to
// WIDTH output FIFOs in round-robin order. A 2-entry buffer decouples the
// input read latency from output back-pressure at full throughput.
//   clk     : clock
//   nrst    : synchronous active-low reset
//   r_empty : input FIFO empty
//   r_req   : input FIFO read request
//   r_data  : input FIFO read data (same cycle in FWFT mode, next cycle else)
//   w_full  : per-port output FIFO full
//   w_req   : per-port write request, one-hot or zero
//   w_data  : per-port write data, every lane carries the head word
// -----------------------------------------------------------------------------
module fifo_splitter
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned WIDTH_W   = clogb2(WIDTH),
   parameter string       FWFT_MODE = "TRUE",
   parameter string       SKIP_FULL = "TRUE",
   parameter int unsigned DATA_W    = 32
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         r_empty,
   output logic                         r_req,
   input  logic [DATA_W-1:0]            r_data,
   input  logic [WIDTH-1:0]             w_full,
   output logic [WIDTH-1:0]             w_req,
   output logic [WIDTH-1:0][DATA_W-1:0] w_data
);

   localparam bit FWFT = (FWFT_MODE == MODE_TRUE);
   localparam bit SKIP = (SKIP_FULL != MODE_FALSE);

   logic [WIDTH_W-1:0] r_rr_ptr;
   logic [WIDTH_W-1:0] w_sel;
   logic               w_sel_valid;
   logic               w_drain;
   logic               w_pend;
   logic               w_push;
   logic [1:0]         w_count;
   logic [DATA_W-1:0]  w_head;
   logic [2:0]         w_inflight;

   // Returns {valid, port}. Skip mode scans rr_ptr, rr_ptr+1, ... for the first
   // free port; strict mode only ever offers rr_ptr.
   function automatic logic [WIDTH_W:0] f_select(input logic [WIDTH-1:0]   full,
                                                 input logic [WIDTH_W-1:0] ptr);
      logic               found;
      logic [WIDTH_W-1:0] idx;
      logic [WIDTH_W-1:0] cand;
      found = 1'b0;
      idx   = ptr;
      if (SKIP) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cand = WIDTH_W'((32'(ptr) + i) % WIDTH);
            if (!found && !full[cand]) begin
               found = 1'b1;
               idx   = cand;
            end
         end
      end else begin
         found = !full[ptr];
      end
      return {found, idx};
   endfunction

   // Normal-mode read data arrives one cycle after r_req; pend marks that cycle.
   generate
      if (FWFT) begin : g_fwft
         assign w_pend = 1'b0;
         assign w_push = r_req;
      end else begin : g_normal
         logic r_pend;
         always_ff @(posedge clk) begin
            if (!nrst) begin
               r_pend <= 1'b0;
            end else begin
               r_pend <= r_req;
            end
         end
         assign w_pend = r_pend;
         assign w_push = r_pend;
      end
   endgenerate

   fifo_splitter_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk         (clk),
      .nrst        (nrst),
      .i_push      (w_push),
      .i_push_data (r_data),
      .i_pop       (w_drain),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   assign {w_sel_valid, w_sel} = f_select(w_full, r_rr_ptr);
   assign w_drain = nrst & (w_count != 2'd0) & w_sel_valid;

   // Words held or in flight, less the one leaving this cycle, must stay below
   // two; counting the drain lets a word enter and leave in the same cycle.
   assign w_inflight = {1'b0, w_count} + {2'b00, w_pend};
   assign r_req = nrst & ~r_empty & (w_inflight < (3'd2 + {2'b00, w_drain}));

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_rr_ptr <= '0;
      end else if (w_drain) begin
         r_rr_ptr <= (w_sel == WIDTH_W'(WIDTH - 1)) ? '0 : w_sel + 1'b1;
      end
   end

   always_comb begin
      w_req  = '0;
      w_data = '0;
      if (w_drain) begin
         w_req[w_sel] = 1'b1;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            w_data[i] = w_head;
         end
      end
   end

endmodule

// File: tb/tb_fifo_splitter.sv
// -----------------------------------------------------------------------------
// tb_fifo_splitter
// Two splitter instances side by side: u_a (FWFT, skip full ports) and
// u_b (normal read latency, strict order). The bench plays the input FIFO and
// keeps, per instance, the list of words read but not yet written together
// with the cycle from which each may be written.
// -----------------------------------------------------------------------------
module tb_fifo_splitter;

   localparam int W  = 3;
   localparam int DW = 8;
   localparam int N  = 2;
   localparam int QN = 4096;
   localparam int LN = 64;

   logic clk = 1'b0;
   logic nrst;
   logic          r_empty [N];
   logic          r_req   [N];
   logic [DW-1:0] r_data  [N];
   logic [W-1:0]  w_full  [N];
   logic [W-1:0]  w_req   [N];
   logic [W-1:0][DW-1:0] w_data [N];

   always #5 clk = ~clk;

   fifo_splitter #(
      .WIDTH(W), .FWFT_MODE("TRUE"), .SKIP_FULL("TRUE"), .DATA_W(DW)
   ) u_a (
      .clk(clk), .nrst(nrst), .r_empty(r_empty[0]), .r_req(r_req[0]),
      .r_data(r_data[0]), .w_full(w_full[0]), .w_req(w_req[0]), .w_data(w_data[0])
   );

   fifo_splitter #(
      .WIDTH(W), .FWFT_MODE("FALSE"), .SKIP_FULL("FALSE"), .DATA_W(DW)
   ) u_b (
      .clk(clk), .nrst(nrst), .r_empty(r_empty[1]), .r_req(r_req[1]),
      .r_data(r_data[1]), .w_full(w_full[1]), .w_req(w_req[1]), .w_data(w_data[1])
   );

   function automatic bit is_fwft(input int k);
      return k == 0;
   endfunction

   function automatic bit is_skip(input int k);
      return k == 0;
   endfunction

   // input FIFO contents
   logic [DW-1:0] src_mem [N][QN];
   int            src_wr  [N];
   int            src_rd  [N];
   // words read from the input, not yet written out
   logic [DW-1:0] out_data  [N][QN];
   int            out_avail [N][QN];
   int            out_wr    [N];
   int            out_rd    [N];
   int            rr        [N];
   logic [DW-1:0] nxt_rdata [N];
   int            tot_rd    [N];
   int            tot_lost  [N];
   int            act_wr    [N];
   // observed activity, for the literal checks
   int lg_port [N][LN];
   int lg_data [N][LN];
   int lg_cyc  [N][LN];
   int lg_n    [N];
   int rq_cyc  [N][LN];
   int rq_n    [N];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   logic         nrst_nx;
   logic [W-1:0] full_nx [N];

   task automatic chk(input string nm, input int k, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
      end
   endtask

   task automatic push(input int k, input logic [DW-1:0] d);
      src_mem[k][src_wr[k]] = d;
      src_wr[k]++;
   endtask

   task automatic clear_logs();
      for (int k = 0; k < N; k++) begin
         lg_n[k] = 0;
         rq_n[k] = 0;
      end
   endtask

   // Advance one cycle and apply the staged input values just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      nrst = nrst_nx;
      for (int k = 0; k < N; k++) begin
         w_full[k]  = full_nx[k];
         r_empty[k] = (src_rd[k] == src_wr[k]);
         if (is_fwft(k)) begin
            r_data[k] = r_empty[k] ? '0 : src_mem[k][src_rd[k]];
         end else begin
            r_data[k] = nxt_rdata[k];
         end
      end
   endtask

   // Per-cycle compare and model update, away from the active edge.
   always @(negedge clk) begin : cmp
      int outs;
      int p;
      int ep;
      bit ed;
      bit er;
      logic [W-1:0]         ew;
      logic [W-1:0][DW-1:0] ewd;
      logic [DW-1:0]        word;
      for (int k = 0; k < N; k++) begin
         outs = out_wr[k] - out_rd[k];
         ed = 1'b0;
         ep = 0;
         if (nrst && outs > 0 && out_avail[k][out_rd[k]] <= cyc) begin
            if (is_skip(k)) begin
               for (int i = 0; i < W; i++) begin
                  p = (rr[k] + i) % W;
                  if (!ed && !w_full[k][p]) begin
                     ed = 1'b1;
                     ep = p;
                  end
               end
            end else if (!w_full[k][rr[k]]) begin
               ed = 1'b1;
               ep = rr[k];
            end
         end
         er  = nrst && !r_empty[k] && ((outs - int'(ed)) < 2);
         ew  = '0;
         ewd = '0;
         if (ed) begin
            ew[ep] = 1'b1;
            for (int i = 0; i < W; i++) ewd[i] = out_data[k][out_rd[k]];
         end
         chk("r_req", k, longint'(r_req[k]), longint'(er));
         chk("w_req", k, longint'(w_req[k]), longint'(ew));
         chk("w_data", k, longint'(w_data[k]), longint'(ewd));

         if (w_req[k] != '0) begin
            act_wr[k]++;
            if (lg_n[k] < LN) begin
               p = 0;
               for (int i = W - 1; i >= 0; i--) if (w_req[k][i]) p = i;
               lg_port[k][lg_n[k]] = p;
               lg_data[k][lg_n[k]] = int'(w_data[k][p]);
               lg_cyc[k][lg_n[k]]  = cyc;
               lg_n[k]++;
            end
         end

         if (ed) begin
            out_rd[k]++;
            rr[k] = (ep + 1) % W;
         end
         if (r_req[k] && src_rd[k] != src_wr[k]) begin
            word = src_mem[k][src_rd[k]];
            src_rd[k]++;
            out_data[k][out_wr[k]]  = word;
            out_avail[k][out_wr[k]] = cyc + (is_fwft(k) ? 1 : 2);
            out_wr[k]++;
            nxt_rdata[k] = word;
            tot_rd[k]++;
            if (rq_n[k] < LN) begin
               rq_cyc[k][rq_n[k]] = cyc;
               rq_n[k]++;
            end
         end
         if (!nrst) begin
            tot_lost[k] += out_wr[k] - out_rd[k];
            out_rd[k] = out_wr[k];
            rr[k] = 0;
         end
      end
      chk("overflow", 0, longint'(nrst && u_a.u_buf.i_push && !u_a.u_buf.i_pop &&
                                  u_a.u_buf.o_count == 2'd2), 0);
      chk("overflow", 1, longint'(nrst && u_b.u_buf.i_push && !u_b.u_buf.i_pop &&
                                  u_b.u_buf.o_count == 2'd2), 0);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int base;
      bit busy;
      nrst    = 1'b0;
      nrst_nx = 1'b0;
      for (int k = 0; k < N; k++) begin
         r_empty[k]   = 1'b1;
         r_data[k]    = '0;
         w_full[k]    = '0;
         full_nx[k]   = '0;
         nxt_rdata[k] = '0;
      end
      clear_logs();

      // 1: words waiting during reset, then free-running distribution
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 6; i++) push(k, DW'(8'h10 + i));
      repeat (3) step();
      nrst_nx = 1'b1;
      repeat (12) step();
      for (int k = 0; k < N; k++) begin
         chk("t1_count", k, lg_n[k], 6);
         for (int i = 0; i < 6; i++) begin
            chk("t1_port", k, lg_port[k][i], i % 3);
            chk("t1_data", k, lg_data[k][i], 8'h10 + i);
            chk("t1_back2back", k, lg_cyc[k][i] - lg_cyc[k][0], i);
         end
         chk("t1_latency", k, lg_cyc[k][0] - rq_cyc[k][0], is_fwft(k) ? 1 : 2);
         chk("t1_rreq_run", k, rq_cyc[k][5] - rq_cyc[k][0], 5);
      end

      // 2: skip mode with port 1 permanently full (instance a only)
      clear_logs();
      full_nx[0] = 3'b010;
      for (int i = 0; i < 4; i++) push(0, DW'(8'hA0 + i));
      repeat (8) step();
      full_nx[0] = '0;
      chk("t2_count", 0, lg_n[0], 4);
      for (int i = 0; i < 4; i++) begin
         chk("t2_port", 0, lg_port[0][i], (i % 2) * 2);
         chk("t2_data", 0, lg_data[0][i], 8'hA0 + i);
      end

      // 3: a all ports full for 4 cycles; b strict with port 1 full for 5
      clear_logs();
      full_nx[0] = 3'b111;
      full_nx[1] = 3'b010;
      for (int i = 0; i < 4; i++) begin
         push(0, DW'(8'hC0 + i));
         push(1, DW'(8'hB0 + i));
      end
      for (int i = 0; i < 10; i++) begin
         if (i == 4) full_nx[0] = '0;
         if (i == 5) full_nx[1] = '0;
         step();
      end
      chk("t3_count", 0, lg_n[0], 4);
      chk("t3_count", 1, lg_n[1], 4);
      base = rq_cyc[0][0];
      chk("t3_rd2", 0, rq_cyc[0][1] - base, 1);
      chk("t3_rd3", 0, rq_cyc[0][2] - base, 4);
      chk("t3_first_wr", 0, lg_cyc[0][0] - base, 4);
      for (int i = 0; i < 4; i++) begin
         chk("t3_port", 0, lg_port[0][i], i % 3);
         chk("t3_data", 0, lg_data[0][i], 8'hC0 + i);
         chk("t3_port", 1, lg_port[1][i], i % 3);
         chk("t3_data", 1, lg_data[1][i], 8'hB0 + i);
      end
      base = rq_cyc[1][0];
      chk("t3_rd3", 1, rq_cyc[1][2] - base, 2);
      chk("t3_rd4", 1, rq_cyc[1][3] - base, 5);
      chk("t3_wr0", 1, lg_cyc[1][0] - base, 2);
      chk("t3_wr1", 1, lg_cyc[1][1] - base, 5);
      chk("t3_wr3", 1, lg_cyc[1][3] - base, 7);

      // 4: reset while the buffer holds two words and rr_ptr is 1
      clear_logs();
      full_nx[0] = 3'b111;
      full_nx[1] = 3'b111;
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 4; i++) push(k, DW'(8'hD0 + i));
      repeat (6) step();
      nrst_nx = 1'b0;
      full_nx[0] = '0;
      full_nx[1] = '0;
      step();
      nrst_nx = 1'b1;
      repeat (8) step();
      for (int k = 0; k < N; k++) begin
         chk("t4_reads", k, rq_n[k], 4);
         chk("t4_count", k, lg_n[k], 2);
         chk("t4_port0", k, lg_port[k][0], 0);
         chk("t4_data0", k, lg_data[k][0], 8'hD2);
         chk("t4_port1", k, lg_port[k][1], 1);
         chk("t4_data1", k, lg_data[k][1], 8'hD3);
      end

      // 5: random traffic, back-pressure and the odd reset
      for (int k = 0; k < N; k++) begin
         act_wr[k]   = 0;
         tot_rd[k]   = 0;
         tot_lost[k] = 0;
      end
      clear_logs();
      for (int c = 0; c < 1500; c++) begin
         nrst_nx = ($urandom_range(0, 299) != 0);
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 2) != 0 && (src_wr[k] - src_rd[k]) < 8)
               push(k, DW'($urandom_range(0, 255)));
            for (int b = 0; b < W; b++) full_nx[k][b] = ($urandom_range(0, 3) == 0);
         end
         step();
      end
      nrst_nx = 1'b1;
      for (int k = 0; k < N; k++) full_nx[k] = '0;
      busy = 1'b1;
      for (int c = 0; c < 200 && busy; c++) begin
         step();
         busy = 1'b0;
         for (int k = 0; k < N; k++)
            if (src_rd[k] != src_wr[k] || out_rd[k] != out_wr[k]) busy = 1'b1;
      end
      chk("drain_timeout", 0, longint'(busy), 0);
      repeat (2) step();
      for (int k = 0; k < N; k++)
         chk("conservation", k, act_wr[k], tot_rd[k] - tot_lost[k]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
